uart_usb_bridge: RTL and testbench

- Byte bridge between a UART pin pair and the USB CDC data endpoints inside the user project.
- The RX path deserialises 8N1 frames from the UART rx pin into an IN stream (in_data/in_valid/in_ready) toward the USB device core.
- The TX path serialises OUT-stream bytes (out_data/out_valid/out_ready) from the USB core onto the UART tx pin.
- Default timing: 48 MHz system clock, 115200 baud.

---
 rtl/uart_bridge_pkg.sv | 17 +
 rtl/uart_rx.sv | 117 +++++++++++
 rtl/uart_usb_bridge.sv | 150 +++++++++++++++
 tb/tb_uart_usb_bridge.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART <-> USB CDC byte bridge.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling FSM, byte plus one-cycle strobe.
// With UART_BRIDGE_FRAME_ERR_EN defined, a low stop-bit sample is reported on frame_err_o.
module uart_rx
  import uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 416
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] byte_o,
  output logic                 strobe_o
`ifdef UART_BRIDGE_FRAME_ERR_EN
  ,
  output logic                 frame_err_o
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic                 rx_meta_q, rx_sync_q;
  uart_state_e          state_q;
  logic [CNT_W-1:0]     clk_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] byte_q;
  logic                 strobe_q;
  logic                 armed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // armed_q drops after a framing error so a line stuck low is not re-read as a new start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      strobe_q  <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
          if (!armed_q) begin
            if (rx_sync_q == 1'b1) armed_q <= 1'b1;
          end else if (rx_sync_q == 1'b0) begin
            state_q <= START;
          end
        end
        START: begin
          if (clk_cnt_q == HALF_END) begin
            clk_cnt_q <= '0;
            if (rx_sync_q == 1'b0) state_q <= DATA;
            else                   state_q <= IDLE;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt_q == BIT_END) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) state_q <= STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt_q == BIT_END) begin
            clk_cnt_q <= '0;
            state_q   <= IDLE;
            if (rx_sync_q == 1'b1) begin
              byte_q   <= shift_q;
              strobe_q <= 1'b1;
            end else begin
              armed_q  <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_o   = byte_q;
  assign strobe_o = strobe_q;

`ifdef UART_BRIDGE_FRAME_ERR_EN
  logic frame_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) frame_err_q <= 1'b0;
    else frame_err_q <= (state_q == STOP) && (clk_cnt_q == BIT_END) && (rx_sync_q == 1'b0);
  end

  assign frame_err_o = frame_err_q;
`endif

endmodule

// File: rtl/uart_usb_bridge.sv
// UART pin pair <-> USB CDC IN/OUT byte streams; RX holding register, overrun flag, TX serialiser.
// Optional rx_frame_err_o output is enabled by defining UART_BRIDGE_FRAME_ERR_EN.
module uart_usb_bridge
  import uart_bridge_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 48000000,
  parameter int BAUD        = 115200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       uart_rx_i,
  output logic       uart_tx_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic       rx_overrun_o
`ifdef UART_BRIDGE_FRAME_ERR_EN
  ,
  output logic       rx_frame_err_o
`endif
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("CLKS_PER_BIT must be at least 4");
  end

  logic [7:0] rx_byte;
  logic       rx_strobe;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rx_i       (uart_rx_i),
    .byte_o     (rx_byte),
    .strobe_o   (rx_strobe)
`ifdef UART_BRIDGE_FRAME_ERR_EN
    ,
    .frame_err_o(rx_frame_err_o)
`endif
  );

  // Both streams: a byte moves on a cycle with valid & ready; valid, once high, holds
  // with stable data until that cycle, and ready never depends on valid combinationally.
  logic [7:0] in_data_q;
  logic       in_valid_q;
  logic       rx_overrun_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_data_q    <= '0;
      in_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_overrun_q <= 1'b0;
      if (rx_strobe) begin
        if (!in_valid_q || in_ready_i) begin
          in_data_q  <= rx_byte;
          in_valid_q <= 1'b1;
        end else begin
          rx_overrun_q <= 1'b1;
        end
      end else if (in_valid_q && in_ready_i) begin
        in_valid_q <= 1'b0;
      end
    end
  end

  uart_state_e      tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [BIT_W-1:0] tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             tx_q;
  logic             out_ready_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q  <= IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      out_ready_q <= 1'b1;
    end else begin
      case (tx_state_q)
        IDLE: begin
          if (out_valid_i && out_ready_q) begin
            tx_shift_q  <= out_data_i;
            tx_q        <= 1'b0;
            out_ready_q <= 1'b0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_state_q  <= START;
          end
        end
        START: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_state_q <= DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
              tx_q       <= 1'b1;
              tx_state_q <= STOP;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= tx_bit_q + 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q    <= '0;
            out_ready_q <= 1'b1;
            tx_state_q  <= IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= IDLE;
      endcase
    end
  end

  assign uart_tx_o    = tx_q;
  assign in_data_o    = in_data_q;
  assign in_valid_o   = in_valid_q;
  assign out_ready_o  = out_ready_q;
  assign rx_overrun_o = rx_overrun_q;

endmodule

// File: tb/tb_uart_usb_bridge.sv
// Bench for uart_usb_bridge: queue model of the IN stream, exact TX waveform checks, loopback.
`timescale 1ns/1ps
module tb_uart_usb_bridge;

  localparam int CPB = 416;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loopback = 1'b0;
  logic       uart_rx_i;
  logic       uart_tx_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i = 1'b1;
  logic [7:0] out_data_i = 8'h00;
  logic       out_valid_i = 1'b0;
  logic       out_ready_o;
  logic       rx_overrun_o;
`ifdef UART_BRIDGE_FRAME_ERR_EN
  logic       rx_frame_err_o;
  int         exp_ferr = 0;
  int         obs_ferr = 0;
`endif

  assign uart_rx_i = loopback ? uart_tx_o : rx_drv;

  uart_usb_bridge dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .uart_rx_i    (uart_rx_i),
    .uart_tx_o    (uart_tx_o),
    .in_data_o    (in_data_o),
    .in_valid_o   (in_valid_o),
    .in_ready_i   (in_ready_i),
    .out_data_i   (out_data_i),
    .out_valid_i  (out_valid_i),
    .out_ready_o  (out_ready_o),
    .rx_overrun_o (rx_overrun_o)
`ifdef UART_BRIDGE_FRAME_ERR_EN
    ,
    .rx_frame_err_o(rx_frame_err_o)
`endif
  );

  // clock / reset
  always #10 clk_i = ~clk_i;

  initial begin
    #(120000 * 20);
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: bytes the DUT must present on the IN stream, in order
  logic [7:0] exp_q[$];
  int exp_ovr = 0;
  int obs_ovr = 0;
  int n_hs = 0;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (in_valid_o) begin
        if (exp_q.size() == 0) begin
          check("in_valid_spurious", in_valid_o, 0);
        end else begin
          check("in_data", in_data_o, exp_q[0]);
          if (in_ready_i) begin
            void'(exp_q.pop_front());
            n_hs++;
          end
        end
      end
      if (rx_overrun_o) obs_ovr++;
`ifdef UART_BRIDGE_FRAME_ERR_EN
      if (rx_frame_err_o) obs_ferr++;
`endif
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_ok);
    rx_drv = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      tick(CPB);
    end
    if (stop_ok) begin
      if (exp_q.size() == 0) exp_q.push_back(b);
      else exp_ovr++;
      rx_drv = 1'b1;
      tick(CPB);
    end else begin
`ifdef UART_BRIDGE_FRAME_ERR_EN
      exp_ferr++;
`endif
      rx_drv = 1'b0;
      tick(2 * CPB);
    end
    rx_drv = 1'b1;
    tick(CPB);
  endtask

  task automatic wait_out_ready();
    int guard = 0;
    while (!out_ready_o && guard < 6000) begin
      tick(1);
      guard++;
    end
    check("out_ready_timeout", out_ready_o, 1);
  endtask

  task automatic tx_send(input logic [7:0] b, input logic expect_rx);
    out_data_i  = b;
    out_valid_i = 1'b1;
    wait_out_ready();
    tick(1);
    out_valid_i = 1'b0;
    if (expect_rx) exp_q.push_back(b);
  endtask

  // entered #1 after the handshake edge; checks both ends of every bit, then the idle cycle
  task automatic tx_frame_check(input string tag, input logic wave [10]);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("%s_bit%0d_head", tag, k), uart_tx_o, wave[k]);
      check($sformatf("%s_busy%0d", tag, k), out_ready_o, 0);
      tick(CPB - 1);
      check($sformatf("%s_bit%0d_tail", tag, k), uart_tx_o, wave[k]);
      tick(1);
    end
    check($sformatf("%s_idle_tx", tag), uart_tx_o, 1);
    check($sformatf("%s_idle_ready", tag), out_ready_o, 1);
  endtask

  logic wave_c3 [10];
  logic wave_01 [10];
  int   hs_mark;

  initial begin
    wave_c3 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    wave_01 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // reset with the rx line undriven
    rx_drv = 1'bx;
    tick(100);
    check("rst_tx", uart_tx_o, 1);
    check("rst_in_valid", in_valid_o, 0);
    check("rst_in_data", in_data_o, 0);
    check("rst_out_ready", out_ready_o, 1);
    check("rst_overrun", rx_overrun_o, 0);
    rst_ni = 1'b1;
    tick(40);
    check("x_line_tx", uart_tx_o, 1);
    check("x_line_in_valid", in_valid_o, 0);
    check("x_line_out_ready", out_ready_o, 1);
    rx_drv = 1'b1;
    tick(300);
    check("idle_in_valid", in_valid_o, 0);
    check("idle_out_ready", out_ready_o, 1);

    // RX sweep 0x00..0x07
    for (int i = 0; i < 8; i++) send_rx(8'(i), 1'b1);
    check("sweep_hs", n_hs, 8);
    check("sweep_drained", exp_q.size(), 0);
    check("sweep_no_overrun", obs_ovr, 0);

    // backpressure
    in_ready_i = 1'b0;
    send_rx(8'hA5, 1'b1);
    send_rx(8'h3C, 1'b1);
    check("bp_overrun", obs_ovr, 1);
    check("bp_valid", in_valid_o, 1);
    check("bp_data", in_data_o, 8'hA5);
    in_ready_i = 1'b1;
    tick(3);
    check("bp_valid_cleared", in_valid_o, 0);
    check("bp_hs", n_hs, 9);
    check("bp_drained", exp_q.size(), 0);

    // glitch and framing error
    hs_mark = n_hs;
    rx_drv = 1'b0;
    tick(100);
    rx_drv = 1'b1;
    tick(CPB);
    check("glitch_in_valid", in_valid_o, 0);
    send_rx(8'h55, 1'b0);
    tick(2 * CPB);
    check("framing_no_byte", n_hs - hs_mark, 0);
    check("framing_in_valid", in_valid_o, 0);
`ifdef UART_BRIDGE_FRAME_ERR_EN
    check("framing_err_pulses", obs_ferr, 1);
`endif

    // TX back-to-back 0xC3, 0x01
    out_data_i  = 8'hC3;
    out_valid_i = 1'b1;
    wait_out_ready();
    tick(1);
    out_data_i = 8'h01;
    tx_frame_check("tx_c3", wave_c3);
    tick(1);
    out_valid_i = 1'b0;
    tx_frame_check("tx_01", wave_01);

    // loopback
    hs_mark  = n_hs;
    loopback = 1'b1;
    tx_send(8'h00, 1'b1);
    tx_send(8'hFF, 1'b1);
    tx_send(8'h5A, 1'b1);
    tick(10 * CPB + 20);
    check("lb_hs", n_hs - hs_mark, 3);
    check("lb_drained", exp_q.size(), 0);

    // reset in the middle of a looped-back frame
    hs_mark = n_hs;
    tx_send(8'h00, 1'b0);
    tick(2000);
    check("mid_rst_tx_low", uart_tx_o, 0);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_tx_high", uart_tx_o, 1);
    check("mid_rst_out_ready", out_ready_o, 1);
    check("mid_rst_in_valid", in_valid_o, 0);
    tick(5);
    rst_ni = 1'b1;
    tick(3 * CPB);
    check("mid_rst_no_byte", n_hs - hs_mark, 0);
    check("mid_rst_in_valid_after", in_valid_o, 0);
    check("mid_rst_tx_idle", uart_tx_o, 1);

    check("overrun_total", obs_ovr, exp_ovr);
`ifdef UART_BRIDGE_FRAME_ERR_EN
    check("frame_err_total", obs_ferr, exp_ferr);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
